exu_lsu_pipe: RTL and testbench
===============================

Name: exu_lsu_pipe

Overview:
- Registered EX→LSU stage boundary, directly downstream of the execute ALU.
- Captures the ALU result, the less/zero flags and per-instruction control; resolves conditional and unconditional branches; forms the writeback/link value; flags misaligned memory accesses.
- Presents a two-entry skid-buffered valid/ready interface to the load/store unit.

Parameters:
- DATA_WIDTH, 64, width of operands, results, PC and branch target.
- RD_WIDTH, 5, destination register index width.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  discards all held and incoming entries this cycle.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept an entry.
- in_pc  in  DATA_WIDTH  PC of the instruction.
- in_alu_out  in  DATA_WIDTH  ALU result; this is the memory address for loads and stores.
- in_less  in  1  ALU less flag.
- in_zero  in  1  ALU zero flag.
- in_br_type  in  3  000 none, 001 beq, 010 bne, 011 blt/bltu, 100 bge/bgeu, 101 jal, 110 jalr.
- in_br_target  in  DATA_WIDTH  precomputed branch/jump target.
- in_rd  in  RD_WIDTH  destination register.
- in_rf_wen  in  1  register write enable.
- in_mem_ren  in  1  load.
- in_mem_wen  in  1  store.
- in_mem_size  in  3  [1:0] = 00 byte, 01 half, 10 word, 11 dword; [2] = unsigned load.
- in_store_data  in  DATA_WIDTH  store data.
- out_valid  out  1  output entry valid.
- out_ready  in  1  LSU accepts the entry.
- out_pc, out_result, out_store_data  out  DATA_WIDTH  registered fields.
- out_rd  out  RD_WIDTH  registered field.
- out_rf_wen, out_mem_ren, out_mem_wen  out  1  registered fields.
- out_mem_size  out  3  registered field.
- out_misalign  out  1  memory access misaligned.
- redirect_valid  out  1  one-cycle taken-branch pulse.
- redirect_pc  out  DATA_WIDTH  redirect target.

Behaviour:
- Reset: while rst_n=0 at a rising edge, main and skid entries are invalidated; out_valid=0, redirect_valid=0, in_ready=1, all data outputs=0. Reset overrides flush and all handshakes.
- Storage is two entries: main (drives out_*) and skid. in_ready = ~skid_valid; it is a registered value with no combinational path from out_ready.
- Accept: in_valid & in_ready. Retire: out_valid & out_ready.
- Accepted entry routing:
  - goes to main if main is empty or main retires this cycle;
  - otherwise goes to skid.
- When main retires and skid is valid, skid moves into main the same edge.
- Order is strictly FIFO. An entry that is accepted and reaches out_valid appears no earlier than the next cycle (latency 1).
- taken is decoded from in_br_type:
  - 001: zero
  - 010: ~zero
  - 011: less
  - 100: ~less
  - 101, 110: 1
  - 000, 111: 0
- On an accepted taken entry:
  - redirect_valid = 1 in the next cycle only.
  - redirect_pc = in_br_target, with bit 0 cleared for jalr (110).
  - Otherwise redirect_valid = 0 and redirect_pc holds its last value.
- result = in_pc + 4 for 101/110 (link value); otherwise in_alu_out. The width is truncated to DATA_WIDTH; wrap-around is allowed.
- misalign is computed only when in_mem_ren | in_mem_wen, else 0:
  - half: addr[0] != 0
  - word: addr[1:0] != 0
  - dword: addr[2:0] != 0
  - byte: never
- Flush: at the edge, main and skid are invalidated. Any same-cycle input is dropped, and in_ready is ignored for that cycle. A redirect is not generated for a dropped entry. A redirect already registered in that cycle still completes its single-cycle pulse.
- Full (both entries valid): in_ready = 0; inputs are held upstream.
- Empty: out_valid = 0; out_* hold their last value.
- While out_valid & ~out_ready, out_* remain stable.
- Simultaneous accept, retire and skid-valid cannot occur, because in_ready = 0 whenever skid is valid.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, release. Required: out_valid=0, redirect_valid=0, in_ready=1; all out_* = 0.
- beq taken: in_br_type=001, in_zero=1, in_br_target=0x80000010, accepted with out_ready=1. Required: next cycle redirect_valid=1 and redirect_pc=0x80000010 for exactly one cycle; out_valid=1 with out_result=in_alu_out. Repeat with in_zero=0: redirect_valid stays 0.
- jalr link: in_pc=0x80000100, in_br_target=0x80000203, in_br_type=110. Required: redirect_pc=0x80000202, out_result=0x80000104.
- Backpressure: out_ready=0, three entries (A, B, C) offered back-to-back. Required: A in main, B in skid, in_ready=0 while C is held. Then out_ready=1: required order A, B, C, no loss or duplication.
- Misalign: word load at 0x1002 → out_misalign=1. Dword store at 0x1008 → out_misalign=0. Byte load at 0x1003 → 0. rf-only op at 0x1001 → 0.
- Flush mid-stream: both entries full, flush=1 together with in_valid=1 for a taken bne. Required: next cycle out_valid=0, in_ready=1, no redirect pulse for the dropped entry.

Source files
------------

// File: rtl/exu_lsu_pipe_if.sv
// EX->LSU stage bundle: upstream entry fields, LSU-side entry fields and the
// branch redirect. The master side is the producer/consumer around the stage,
// the slave side is the stage itself.
interface exu_lsu_pipe_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned RD_WIDTH   = 5
);
    logic                  flush;

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_pc;
    logic [DATA_WIDTH-1:0] in_alu_out;
    logic                  in_less;
    logic                  in_zero;
    logic [2:0]            in_br_type;
    logic [DATA_WIDTH-1:0] in_br_target;
    logic [RD_WIDTH-1:0]   in_rd;
    logic                  in_rf_wen;
    logic                  in_mem_ren;
    logic                  in_mem_wen;
    logic [2:0]            in_mem_size;
    logic [DATA_WIDTH-1:0] in_store_data;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_pc;
    logic [DATA_WIDTH-1:0] out_result;
    logic [DATA_WIDTH-1:0] out_store_data;
    logic [RD_WIDTH-1:0]   out_rd;
    logic                  out_rf_wen;
    logic                  out_mem_ren;
    logic                  out_mem_wen;
    logic [2:0]            out_mem_size;
    logic                  out_misalign;

    logic                  redirect_valid;
    logic [DATA_WIDTH-1:0] redirect_pc;

    modport master (
        output flush, in_valid, in_pc, in_alu_out, in_less, in_zero, in_br_type,
               in_br_target, in_rd, in_rf_wen, in_mem_ren, in_mem_wen, in_mem_size,
               in_store_data, out_ready,
        input  in_ready, out_valid, out_pc, out_result, out_store_data, out_rd,
               out_rf_wen, out_mem_ren, out_mem_wen, out_mem_size, out_misalign,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  flush, in_valid, in_pc, in_alu_out, in_less, in_zero, in_br_type,
               in_br_target, in_rd, in_rf_wen, in_mem_ren, in_mem_wen, in_mem_size,
               in_store_data, out_ready,
        output in_ready, out_valid, out_pc, out_result, out_store_data, out_rd,
               out_rf_wen, out_mem_ren, out_mem_wen, out_mem_size, out_misalign,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/exu_lsu_pipe.sv
// Registered EX->LSU boundary: resolves branches, forms the link/result value,
// flags misaligned accesses and hands entries to the LSU through a two-entry
// (main + skid) buffer whose in_ready is purely registered.
module exu_lsu_pipe #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned RD_WIDTH   = 5
) (
    input logic           clk,
    input logic           rst_n,
    exu_lsu_pipe_if.slave bus
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] result;
        logic [DATA_WIDTH-1:0] store_data;
        logic [RD_WIDTH-1:0]   rd;
        logic                  rf_wen;
        logic                  mem_ren;
        logic                  mem_wen;
        logic [2:0]            mem_size;
        logic                  misalign;
    } entry_t;

    entry_t                main_q, main_d;
    entry_t                skid_q, skid_d;
    logic                  main_valid_q, main_valid_d;
    logic                  skid_valid_q, skid_valid_d;
    logic                  redirect_valid_q, redirect_valid_d;
    logic [DATA_WIDTH-1:0] redirect_pc_q, redirect_pc_d;

    entry_t                new_entry;
    logic                  taken;
    logic                  is_jump;
    logic                  accept;
    logic                  retire;

    // Decode the incoming instruction into a stored entry and branch outcome.
    always_comb begin
        taken   = 1'b0;
        is_jump = 1'b0;
        case (bus.in_br_type)
            3'b001:  taken = bus.in_zero;
            3'b010:  taken = ~bus.in_zero;
            3'b011:  taken = bus.in_less;
            3'b100:  taken = ~bus.in_less;
            3'b101,
            3'b110: begin
                taken   = 1'b1;
                is_jump = 1'b1;
            end
            default: taken = 1'b0;
        endcase

        new_entry            = '0;
        new_entry.pc         = bus.in_pc;
        new_entry.result     = is_jump ? bus.in_pc + DATA_WIDTH'(4) : bus.in_alu_out;
        new_entry.store_data = bus.in_store_data;
        new_entry.rd         = bus.in_rd;
        new_entry.rf_wen     = bus.in_rf_wen;
        new_entry.mem_ren    = bus.in_mem_ren;
        new_entry.mem_wen    = bus.in_mem_wen;
        new_entry.mem_size   = bus.in_mem_size;
        if (bus.in_mem_ren | bus.in_mem_wen) begin
            case (bus.in_mem_size[1:0])
                2'b01:   new_entry.misalign = bus.in_alu_out[0];
                2'b10:   new_entry.misalign = |bus.in_alu_out[1:0];
                2'b11:   new_entry.misalign = |bus.in_alu_out[2:0];
                default: new_entry.misalign = 1'b0;
            endcase
        end
    end

    // Flush drops the incoming entry, so it never counts as accepted.
    assign accept = bus.in_valid & ~skid_valid_q & ~bus.flush;
    assign retire = main_valid_q & bus.out_ready;

    // Main/skid routing and redirect generation.
    always_comb begin
        main_d           = main_q;
        skid_d           = skid_q;
        main_valid_d     = main_valid_q;
        skid_valid_d     = skid_valid_q;
        redirect_valid_d = accept & taken;
        redirect_pc_d    = redirect_pc_q;

        if (accept & taken) begin
            redirect_pc_d = bus.in_br_target;
            if (bus.in_br_type == 3'b110) begin
                redirect_pc_d[0] = 1'b0;
            end
        end

        if (bus.flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (retire) begin
            // Accept cannot coincide with a valid skid, so these are exclusive.
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = new_entry;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (!main_valid_q) begin
            if (accept) begin
                main_d       = new_entry;
                main_valid_d = 1'b1;
            end
        end else if (accept) begin
            skid_d       = new_entry;
            skid_valid_d = 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q           <= '0;
            skid_q           <= '0;
            main_valid_q     <= 1'b0;
            skid_valid_q     <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            main_q           <= main_d;
            skid_q           <= skid_d;
            main_valid_q     <= main_valid_d;
            skid_valid_q     <= skid_valid_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign bus.in_ready       = ~skid_valid_q;
    assign bus.out_valid      = main_valid_q;
    assign bus.out_pc         = main_q.pc;
    assign bus.out_result     = main_q.result;
    assign bus.out_store_data = main_q.store_data;
    assign bus.out_rd         = main_q.rd;
    assign bus.out_rf_wen     = main_q.rf_wen;
    assign bus.out_mem_ren    = main_q.mem_ren;
    assign bus.out_mem_wen    = main_q.mem_wen;
    assign bus.out_mem_size   = main_q.mem_size;
    assign bus.out_misalign   = main_q.misalign;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_exu_lsu_pipe.sv
// Directed bench for exu_lsu_pipe: reset, branch resolution, link value,
// backpressure ordering, misalignment and flush.
module tb_exu_lsu_pipe;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    exu_lsu_pipe_if #(.DATA_WIDTH(64), .RD_WIDTH(5)) bus ();

    exu_lsu_pipe #(.DATA_WIDTH(64), .RD_WIDTH(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs and samples both sit 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [63:0] pc, input logic [63:0] alu, input logic [2:0] br,
                          input logic zero, input logic less, input logic [63:0] tgt);
        bus.in_valid     = 1'b1;
        bus.in_pc        = pc;
        bus.in_alu_out   = alu;
        bus.in_br_type   = br;
        bus.in_zero      = zero;
        bus.in_less      = less;
        bus.in_br_target = tgt;
        bus.in_mem_ren   = 1'b0;
        bus.in_mem_wen   = 1'b0;
        bus.in_mem_size  = 3'b000;
    endtask

    task automatic set_mem(input logic [63:0] addr, input logic ren, input logic wen,
                           input logic [2:0] size);
        set_op(64'h100, addr, 3'b000, 1'b0, 1'b0, 64'h0);
        bus.in_mem_ren  = ren;
        bus.in_mem_wen  = wen;
        bus.in_mem_size = size;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.flush         = 1'b0;
        bus.in_valid      = 1'b0;
        bus.in_pc         = '0;
        bus.in_alu_out    = '0;
        bus.in_less       = 1'b0;
        bus.in_zero       = 1'b0;
        bus.in_br_type    = 3'b000;
        bus.in_br_target  = '0;
        bus.in_rd         = 5'd3;
        bus.in_rf_wen     = 1'b1;
        bus.in_mem_ren    = 1'b0;
        bus.in_mem_wen    = 1'b0;
        bus.in_mem_size   = 3'b000;
        bus.in_store_data = 64'hdead_beef;
        bus.out_ready     = 1'b1;

        // Reset then idle
        step();
        step();
        rst_n = 1'b1;
        step();
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_redirect", 64'(bus.redirect_valid), 64'd0);
        check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check_eq("rst_out_pc", bus.out_pc, 64'd0);
        check_eq("rst_out_result", bus.out_result, 64'd0);
        check_eq("rst_out_store", bus.out_store_data, 64'd0);
        check_eq("rst_out_misalign", 64'(bus.out_misalign), 64'd0);
        check_eq("rst_redirect_pc", bus.redirect_pc, 64'd0);

        // beq taken
        set_op(64'h8000_0000, 64'h1234, 3'b001, 1'b1, 1'b0, 64'h8000_0010);
        step();
        bus.in_valid = 1'b0;
        check_eq("beq_t_redir", 64'(bus.redirect_valid), 64'd1);
        check_eq("beq_t_redir_pc", bus.redirect_pc, 64'h8000_0010);
        check_eq("beq_t_valid", 64'(bus.out_valid), 64'd1);
        check_eq("beq_t_result", bus.out_result, 64'h1234);
        check_eq("beq_t_pc", bus.out_pc, 64'h8000_0000);
        step();
        check_eq("beq_t_pulse_end", 64'(bus.redirect_valid), 64'd0);
        check_eq("beq_t_retired", 64'(bus.out_valid), 64'd0);
        check_eq("beq_t_hold", bus.out_result, 64'h1234);

        // beq not taken
        set_op(64'h8000_0004, 64'h5678, 3'b001, 1'b0, 1'b0, 64'h8000_0020);
        step();
        bus.in_valid = 1'b0;
        check_eq("beq_nt_redir", 64'(bus.redirect_valid), 64'd0);
        check_eq("beq_nt_redir_pc", bus.redirect_pc, 64'h8000_0010);
        check_eq("beq_nt_result", bus.out_result, 64'h5678);
        step();

        // jalr link
        set_op(64'h8000_0100, 64'h0, 3'b110, 1'b0, 1'b0, 64'h8000_0203);
        step();
        bus.in_valid = 1'b0;
        check_eq("jalr_redir", 64'(bus.redirect_valid), 64'd1);
        check_eq("jalr_redir_pc", bus.redirect_pc, 64'h8000_0202);
        check_eq("jalr_result", bus.out_result, 64'h8000_0104);
        step();

        // Backpressure: A, B, C back-to-back with LSU stalled
        bus.out_ready = 1'b0;
        set_op(64'h10, 64'hA, 3'b000, 1'b0, 1'b0, 64'h0);
        step();
        check_eq("bp_a_main", bus.out_result, 64'hA);
        check_eq("bp_a_ready", 64'(bus.in_ready), 64'd1);
        set_op(64'h14, 64'hB, 3'b000, 1'b0, 1'b0, 64'h0);
        step();
        check_eq("bp_full_ready", 64'(bus.in_ready), 64'd0);
        set_op(64'h18, 64'hC, 3'b000, 1'b0, 1'b0, 64'h0);
        step();
        check_eq("bp_c_held_ready", 64'(bus.in_ready), 64'd0);
        check_eq("bp_a_stable", bus.out_result, 64'hA);
        check_eq("bp_a_valid", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b1;
        step();
        check_eq("bp_b_second", bus.out_result, 64'hB);
        check_eq("bp_b_ready", 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0;
        check_eq("bp_c_third", bus.out_result, 64'hC);
        check_eq("bp_c_valid", 64'(bus.out_valid), 64'd1);
        step();
        check_eq("bp_no_dup", 64'(bus.out_valid), 64'd0);

        // Misalignment
        set_mem(64'h1002, 1'b1, 1'b0, 3'b010);
        step();
        check_eq("mis_word", 64'(bus.out_misalign), 64'd1);
        set_mem(64'h1008, 1'b0, 1'b1, 3'b011);
        step();
        check_eq("mis_dword", 64'(bus.out_misalign), 64'd0);
        set_mem(64'h1003, 1'b1, 1'b0, 3'b000);
        step();
        check_eq("mis_byte", 64'(bus.out_misalign), 64'd0);
        set_mem(64'h1001, 1'b0, 1'b0, 3'b010);
        step();
        check_eq("mis_rf_only", 64'(bus.out_misalign), 64'd0);
        set_mem(64'h1001, 1'b1, 1'b0, 3'b101);
        step();
        check_eq("mis_half", 64'(bus.out_misalign), 64'd1);
        check_eq("mis_half_size", 64'(bus.out_mem_size), 64'd5);
        bus.in_valid = 1'b0;
        step();

        // Flush with both entries full and a taken bne arriving
        bus.out_ready = 1'b0;
        set_op(64'h20, 64'h11, 3'b000, 1'b0, 1'b0, 64'h0);
        step();
        set_op(64'h24, 64'h22, 3'b000, 1'b0, 1'b0, 64'h0);
        step();
        check_eq("fl_full_ready", 64'(bus.in_ready), 64'd0);
        set_op(64'h28, 64'h33, 3'b010, 1'b0, 1'b0, 64'h9000_0000);
        bus.flush = 1'b1;
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check_eq("fl_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("fl_in_ready", 64'(bus.in_ready), 64'd1);
        check_eq("fl_no_redir", 64'(bus.redirect_valid), 64'd0);
        step();
        check_eq("fl_no_redir2", 64'(bus.redirect_valid), 64'd0);
        check_eq("fl_still_empty", 64'(bus.out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
